// File: rtl/s2mm_bridge_pkg.sv
// s2mm_bridge_pkg: FSM encoding, response codes, DataMover command/status field positions
package s2mm_bridge_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_STS, S_RESP} state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int BTT_LSB = 0;
  localparam int BTT_W = 23;
  localparam int TYPE_BIT = 23;
  localparam int EOF_BIT = 30;
  localparam int SADDR_LSB = 32;
  localparam int TAG_LSB = 64;
  localparam int TAG_W = 4;
  localparam int STS_TAG_LSB = 0;
  localparam int STS_INTERR_BIT = 4;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_OKAY_BIT = 7;
  // Map the low status byte to a write response; tag is the tag of the command just issued
  function automatic logic [1:0] sts_decode(input logic [7:0] sts, input logic [TAG_W-1:0] tag,
                                            input logic len_err);
    return sts[STS_DECERR_BIT] ? RESP_DECERR :
           (sts[STS_SLVERR_BIT] | sts[STS_INTERR_BIT] | (sts[STS_TAG_LSB +: TAG_W] != tag) |
            len_err | !sts[STS_OKAY_BIT]) ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/s2mm_axis_reg.sv
// s2mm_axis_reg: 1-deep AXI-Stream output register carrying data, keep and last
module s2mm_axis_reg #(
  parameter int DW = 64,
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic [KW-1:0] s_keep,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [KW-1:0] m_keep,
  output logic          m_last
);
  logic          valid_q, valid_d, last_q, last_d, load;
  logic [DW-1:0] data_q, data_d;
  logic [KW-1:0] keep_q, keep_d;

  assign s_ready = !valid_q || m_ready;
  assign load = s_valid && s_ready;
  assign m_valid = valid_q;
  assign m_data = data_q;
  assign m_keep = keep_q;
  assign m_last = last_q;

  // Capture a new beat when the slot is free or draining this cycle
  always_comb begin
    valid_d = load ? 1'b1 : (m_ready ? 1'b0 : valid_q);
    data_d = load ? s_data : data_q;
    keep_d = load ? s_keep : keep_q;
    last_d = load ? s_last : last_q;
  end

  // Slot registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
    end
endmodule

// File: rtl/s2mm_wr_bridge.sv
// s2mm_wr_bridge: write-request to AXI DataMover S2MM bridge; S2MM_STS_TIMEOUT_EN adds a status watchdog
module s2mm_wr_bridge
  import s2mm_bridge_pkg::*;
#(
  parameter int S2MM_DATA_WIDTH = 64,
  parameter int S2MM_CMD_WIDTH = 72,
  parameter int S2MM_ADDR_WIDTH = 32,
  parameter int S2MM_SIZE_WIDTH = 16,
  parameter int S2MM_STS_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         wreq_ready,
  input  logic                         wreq_valid,
  input  logic [S2MM_ADDR_WIDTH-1:0]   wreq_addr,
  input  logic [S2MM_SIZE_WIDTH-1:0]   wreq_size,
  output logic                         wdata_ready,
  input  logic                         wdata_valid,
  input  logic                         wdata_last,
  input  logic [S2MM_DATA_WIDTH-1:0]   wdata,
  output logic                         wresp_valid,
  output logic [1:0]                   wresp,
  output logic                         m_axis_s2mm_cmd_tvalid,
  input  logic                         m_axis_s2mm_cmd_tready,
  output logic [S2MM_CMD_WIDTH-1:0]    m_axis_s2mm_cmd_tdata,
  output logic                         m_axis_s2mm_tvalid,
  input  logic                         m_axis_s2mm_tready,
  output logic [S2MM_DATA_WIDTH-1:0]   m_axis_s2mm_tdata,
  output logic [S2MM_DATA_WIDTH/8-1:0] m_axis_s2mm_tkeep,
  output logic                         m_axis_s2mm_tlast,
  input  logic                         s_axis_s2mm_sts_tvalid,
  output logic                         s_axis_s2mm_sts_tready,
  input  logic [S2MM_STS_WIDTH-1:0]    s_axis_s2mm_sts_tdata,
  output logic                         busy
);
  localparam int KW = S2MM_DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(KW);
  localparam int SW = S2MM_SIZE_WIDTH;

  state_e                     state_q, state_d;
  logic [S2MM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SW-1:0]              size_q, size_d, cnt_q, cnt_d, beats, rem;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic                       len_err_q, len_err_d;
  logic [1:0]                 resp_q, resp_d;
  logic [S2MM_CMD_WIDTH-1:0]  cmd;
  logic [KW-1:0]              keep;
  logic                       idle, slice_ready, in_fire, is_last, done, out_last_fire;
  logic                       unused_sts;

`ifdef S2MM_STS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  assign tmo_hit = tmo_q == TMO_W'(TIMEOUT_CYCLES - 1);
  assign unused_sts = ^s_axis_s2mm_sts_tdata[S2MM_STS_WIDTH-1:8];
`else
  assign unused_sts = ^{s_axis_s2mm_sts_tdata[S2MM_STS_WIDTH-1:8], TIMEOUT_CYCLES[0]};
`endif

  assign idle = state_q == S_IDLE;
  assign beats = SW'(({1'b0, size_q} + (SW + 1)'(KW - 1)) >> OFF_W);
  assign rem = size_q & SW'(KW - 1);
  assign done = cnt_q == beats;
  assign is_last = cnt_q == beats - 1'b1;
  assign keep = (is_last && rem != '0) ? KW'((1 << rem) - 1) : '1;
  assign wdata_ready = state_q == S_DATA && !done && slice_ready;
  assign in_fire = wdata_valid && wdata_ready;
  assign out_last_fire = m_axis_s2mm_tvalid && m_axis_s2mm_tready && m_axis_s2mm_tlast;

  assign wreq_ready = idle && !rst;
  assign s_axis_s2mm_sts_tready = (idle || state_q == S_STS) && !rst;
  assign m_axis_s2mm_cmd_tvalid = state_q == S_CMD;
  assign m_axis_s2mm_cmd_tdata = (state_q == S_CMD) ? cmd : '0;
  assign wresp_valid = state_q == S_RESP;
  assign wresp = (state_q == S_RESP) ? resp_q : 2'b00;
  assign busy = !idle;

  // Assemble the DataMover command from the latched request
  always_comb begin
    cmd = '0;
    cmd[BTT_LSB +: BTT_W] = BTT_W'(size_q);
    cmd[TYPE_BIT] = 1'b1;
    cmd[EOF_BIT] = 1'b1;
    cmd[SADDR_LSB +: S2MM_ADDR_WIDTH] = addr_q;
    cmd[TAG_LSB +: TAG_W] = tag_q;
  end

  // Next-state and datapath updates; beat count, not wdata_last, bounds the transfer
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    size_d = size_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    len_err_d = len_err_q;
    resp_d = resp_q;
`ifdef S2MM_STS_TIMEOUT_EN
    tmo_d = (state_q == S_STS) ? tmo_q + 1'b1 : '0;
`endif
    unique case (state_q)
      S_IDLE:
        if (wreq_valid) begin
          addr_d = wreq_addr;
          size_d = wreq_size;
          cnt_d = '0;
          len_err_d = 1'b0;
          resp_d = RESP_SLVERR;
          state_d = (wreq_size == '0) ? S_RESP : S_CMD;
        end
      S_CMD:
        if (m_axis_s2mm_cmd_tready) begin
          tag_d = tag_q + 1'b1;
          state_d = S_DATA;
        end
      S_DATA: begin
        if (in_fire) begin
          cnt_d = cnt_q + 1'b1;
          len_err_d = len_err_q | (wdata_last != is_last);
        end
        if (out_last_fire) state_d = S_STS;
      end
      S_STS:
        if (s_axis_s2mm_sts_tvalid) begin
          resp_d = sts_decode(s_axis_s2mm_sts_tdata[7:0], tag_q - 1'b1, len_err_q);
          state_d = S_RESP;
        end
`ifdef S2MM_STS_TIMEOUT_EN
        else if (tmo_hit) begin
          resp_d = RESP_SLVERR;
          state_d = S_RESP;
        end
`endif
      S_RESP: begin
        len_err_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      size_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      len_err_q <= 1'b0;
      resp_q <= 2'b00;
`ifdef S2MM_STS_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      size_q <= size_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      len_err_q <= len_err_d;
      resp_q <= resp_d;
`ifdef S2MM_STS_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end

  s2mm_axis_reg #(.DW(S2MM_DATA_WIDTH), .KW(KW)) u_axis_reg (
    .clk(clk),
    .rst(rst),
    .s_valid(in_fire),
    .s_ready(slice_ready),
    .s_data(wdata),
    .s_keep(keep),
    .s_last(is_last),
    .m_valid(m_axis_s2mm_tvalid),
    .m_ready(m_axis_s2mm_tready),
    .m_data(m_axis_s2mm_tdata),
    .m_keep(m_axis_s2mm_tkeep),
    .m_last(m_axis_s2mm_tlast)
  );
endmodule

// File: tb/tb_s2mm_wr_bridge.sv
// tb_s2mm_wr_bridge: randomized self-checking bench for s2mm_wr_bridge against a transfer-level model
module tb_s2mm_wr_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wreq_ready, wreq_valid = 1'b0;
  logic [31:0] wreq_addr = '0;
  logic [15:0] wreq_size = '0;
  logic        wdata_ready, wdata_valid = 1'b0, wdata_last = 1'b0;
  logic [63:0] wdata = '0;
  logic        wresp_valid;
  logic [1:0]  wresp;
  logic        m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tready = 1'b0;
  logic [71:0] m_axis_s2mm_cmd_tdata;
  logic        m_axis_s2mm_tvalid, m_axis_s2mm_tready = 1'b0, m_axis_s2mm_tlast;
  logic [63:0] m_axis_s2mm_tdata;
  logic [7:0]  m_axis_s2mm_tkeep;
  logic        s_axis_s2mm_sts_tvalid = 1'b0, s_axis_s2mm_sts_tready;
  logic [31:0] s_axis_s2mm_sts_tdata = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int exp_tag = 0;
  logic [71:0] cmd_q[$];
  logic [63:0] dat_q[$];
  logic [7:0]  keep_q[$];
  logic        last_q[$];

  always #5 clk = ~clk;

  s2mm_wr_bridge dut (
    .clk(clk), .rst(rst),
    .wreq_ready(wreq_ready), .wreq_valid(wreq_valid), .wreq_addr(wreq_addr), .wreq_size(wreq_size),
    .wdata_ready(wdata_ready), .wdata_valid(wdata_valid), .wdata_last(wdata_last), .wdata(wdata),
    .wresp_valid(wresp_valid), .wresp(wresp),
    .m_axis_s2mm_cmd_tvalid(m_axis_s2mm_cmd_tvalid), .m_axis_s2mm_cmd_tready(m_axis_s2mm_cmd_tready),
    .m_axis_s2mm_cmd_tdata(m_axis_s2mm_cmd_tdata),
    .m_axis_s2mm_tvalid(m_axis_s2mm_tvalid), .m_axis_s2mm_tready(m_axis_s2mm_tready),
    .m_axis_s2mm_tdata(m_axis_s2mm_tdata), .m_axis_s2mm_tkeep(m_axis_s2mm_tkeep),
    .m_axis_s2mm_tlast(m_axis_s2mm_tlast),
    .s_axis_s2mm_sts_tvalid(s_axis_s2mm_sts_tvalid), .s_axis_s2mm_sts_tready(s_axis_s2mm_sts_tready),
    .s_axis_s2mm_sts_tdata(s_axis_s2mm_sts_tdata),
    .busy(busy)
  );

  // Record every command and data handshake the DUT completes
  always @(negedge clk)
    if (!rst) begin
      if (m_axis_s2mm_cmd_tvalid && m_axis_s2mm_cmd_tready) cmd_q.push_back(m_axis_s2mm_cmd_tdata);
      if (m_axis_s2mm_tvalid && m_axis_s2mm_tready) begin
        dat_q.push_back(m_axis_s2mm_tdata);
        keep_q.push_back(m_axis_s2mm_tkeep);
        last_q.push_back(m_axis_s2mm_tlast);
      end
    end

  function automatic logic [1:0] model_resp(input int sts, input int tag, input bit lerr);
    if ((sts / 32) % 2 == 1) return 2'b11;
    if ((sts / 64) % 2 == 1 || (sts / 16) % 2 == 1 || sts % 16 != tag || lerr || (sts / 128) % 2 == 0)
      return 2'b10;
    return 2'b00;
  endfunction

  task automatic idle_inputs;
    wreq_valid = 0; wdata_valid = 0; wdata_last = 0;
    m_axis_s2mm_cmd_tready = 0; m_axis_s2mm_tready = 0; s_axis_s2mm_sts_tvalid = 0;
  endtask

  // One complete write: request, command, data, status, response; checked against the model
  task automatic run_xfer(input logic [31:0] addr, input logic [15:0] size, input int bad_last,
                          input logic [3:0] sts_hi, input int tag_delta, input int rdy_pct,
                          input bit no_sts, input bit noise, input string name);
    int beats, rem, idx, lat, budget, w;
    bit got, sts_sent, lerr;
    logic [1:0] got_resp, exp_resp;
    logic [7:0] sts8, ekeep;
    logic [63:0] data[$];
    logic [71:0] exp_cmd;
    beats = (int'(size) + 7) / 8;
    rem = int'(size) % 8;
    for (int i = 0; i < beats; i++) data.push_back({$urandom, $urandom});
    sts8 = {sts_hi, 4'((exp_tag + tag_delta) % 16)};
    lerr = bad_last >= 0 && bad_last != beats - 1;
    exp_resp = (size == 0 || no_sts) ? 2'b10 : model_resp(int'(sts8), exp_tag, lerr);
    exp_cmd = 72'(size) + (72'd1 << 23) + (72'd1 << 30) + (72'(addr) << 32) + (72'(exp_tag) << 64);
    budget = no_sts ? 6000 : 2000;
    cmd_q.delete(); dat_q.delete(); keep_q.delete(); last_q.delete();
    idx = 0; lat = 0; got = 0; sts_sent = 0; got_resp = 2'b00;
    w = 0;
    @(negedge clk);
    while (!wreq_ready && w < 50) begin @(negedge clk); w++; end
    n_checks++;
    if (wreq_ready !== 1'b1) begin n_fail++; $display("FAIL %s wreq_ready: got %b want 1", name, wreq_ready); end
    @(posedge clk); #1;
    wreq_valid = 1; wreq_addr = addr; wreq_size = size;
    @(posedge clk); #1;
    wreq_valid = 0;
    for (int k = 0; k < budget && !got; k++) begin
      m_axis_s2mm_cmd_tready = 1'($urandom_range(0, 1));
      m_axis_s2mm_tready = $urandom_range(0, 99) < rdy_pct;
      wdata_valid = idx < beats && $urandom_range(0, 3) != 0;
      wdata = idx < beats ? data[idx] : 64'h0;
      wdata_last = (bad_last >= 0) ? (idx == bad_last) : (idx == beats - 1);
      s_axis_s2mm_sts_tvalid = !no_sts && beats > 0 && !sts_sent && dat_q.size() == beats;
      s_axis_s2mm_sts_tdata = {24'($urandom), sts8};
      wreq_valid = noise && busy && !wresp_valid && $urandom_range(0, 2) == 0;
      wreq_addr = $urandom; wreq_size = 16'($urandom);
      @(negedge clk);
      if (wdata_valid && wdata_ready) idx++;
      if (s_axis_s2mm_sts_tvalid && s_axis_s2mm_sts_tready) sts_sent = 1;
      if (wresp_valid) begin got = 1; got_resp = wresp; lat = k; end
      @(posedge clk); #1;
    end
    idle_inputs();
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL %s timeout: no wresp within %0d cycles", name, budget); end
    else if (got_resp !== exp_resp) begin
      n_fail++; $display("FAIL %s wresp: got %b want %b", name, got_resp, exp_resp);
    end
    @(negedge clk);
    n_checks++;
    if (wresp_valid !== 1'b0 || wresp !== 2'b00) begin
      n_fail++; $display("FAIL %s wresp pulse: valid=%b wresp=%b after one cycle, want 0/00", name, wresp_valid, wresp);
    end
    if (size == 0) begin
      n_checks++;
      if (cmd_q.size() != 0 || lat > 1) begin
        n_fail++; $display("FAIL %s zero size: cmds=%0d latency=%0d want 0 cmds, latency<2", name, cmd_q.size(), lat);
      end
    end else begin
      n_checks++;
      if (cmd_q.size() != 1 || cmd_q[0] !== exp_cmd) begin
        n_fail++;
        $display("FAIL %s cmd: got %0d cmds first %h want 1 cmd %h", name, cmd_q.size(),
                 cmd_q.size() > 0 ? cmd_q[0] : 72'h0, exp_cmd);
      end
      n_checks++;
      if (dat_q.size() != beats) begin
        n_fail++; $display("FAIL %s beat count: got %0d want %0d", name, dat_q.size(), beats);
      end
      for (int i = 0; i < beats && i < dat_q.size(); i++) begin
        ekeep = (i == beats - 1 && rem != 0) ? (8'hFF >> (8 - rem)) : 8'hFF;
        n_checks++;
        if (dat_q[i] !== data[i] || keep_q[i] !== ekeep || last_q[i] !== (i == beats - 1)) begin
          n_fail++;
          $display("FAIL %s beat %0d: got data %h keep %h last %b want %h %h %b", name, i,
                   dat_q[i], keep_q[i], last_q[i], data[i], ekeep, i == beats - 1);
        end
      end
      exp_tag = (exp_tag + 1) % 16;
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({wreq_ready, wdata_ready, wresp_valid, wresp, m_axis_s2mm_cmd_tvalid, m_axis_s2mm_tvalid,
         m_axis_s2mm_tlast, m_axis_s2mm_tkeep, s_axis_s2mm_sts_tready, busy} !== 17'h0) begin
      n_fail++; $display("FAIL reset ctrl: rdy=%b busy=%b stsrdy=%b want all 0", wreq_ready, busy, s_axis_s2mm_sts_tready);
    end
    n_checks++;
    if (m_axis_s2mm_cmd_tdata !== 72'h0 || m_axis_s2mm_tdata !== 64'h0) begin
      n_fail++; $display("FAIL reset data: cmd %h data %h want 0", m_axis_s2mm_cmd_tdata, m_axis_s2mm_tdata);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (wreq_ready !== 1'b1 || busy !== 1'b0 || s_axis_s2mm_sts_tready !== 1'b1) begin
      n_fail++; $display("FAIL post-reset: rdy=%b busy=%b stsrdy=%b want 1 0 1", wreq_ready, busy, s_axis_s2mm_sts_tready);
    end
    exp_tag = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run_xfer(32'h1000, 16'h0100, -1, 4'h8, 0, 100, 0, 0, "basic");
    run_xfer(32'h2000, 16'h0014, -1, 4'h8, 0, 100, 0, 0, "partial");
  endtask

  task automatic test_backpressure;
    run_xfer(32'h3000, 16'h0100, -1, 4'h8, 0, 50, 0, 0, "backpressure");
  endtask

  task automatic test_status_err;
    run_xfer(32'h4000, 16'h0040, -1, 4'h4, 1, 100, 0, 0, "sts_0x41");
    run_xfer(32'h4100, 16'h0010, -1, 4'hA, 0, 80, 0, 0, "sts_decerr");
    run_xfer(32'h4200, 16'h0009, -1, 4'h8, 3, 80, 0, 0, "sts_tag");
    run_xfer(32'h4300, 16'h0018, -1, 4'h0, 0, 80, 0, 0, "sts_not_okay");
    run_xfer(32'h4400, 16'h0008, -1, 4'h9, 0, 80, 0, 0, "sts_interr");
  endtask

  task automatic test_len_err;
    run_xfer(32'h5000, 16'h0100, 10, 4'h8, 0, 70, 0, 0, "last_early");
    run_xfer(32'h5100, 16'h0021, 99, 4'h8, 0, 70, 0, 0, "last_missing");
    run_xfer(32'h5200, 16'h0030, -1, 4'h8, 0, 70, 0, 0, "len_err_cleared");
  endtask

  task automatic test_zero_size;
    run_xfer(32'h6000, 16'h0000, -1, 4'h8, 0, 100, 0, 0, "zero_size");
  endtask

  task automatic test_drain;
    bit bad;
    bad = 0;
    s_axis_s2mm_sts_tdata = 32'h0000_0080;
    for (int k = 0; k < 3; k++) begin
      s_axis_s2mm_sts_tvalid = 1;
      @(negedge clk);
      if (s_axis_s2mm_sts_tready !== 1'b1 || wresp_valid !== 1'b0 || busy !== 1'b0) bad = 1;
      @(posedge clk); #1;
    end
    s_axis_s2mm_sts_tvalid = 0;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL drain: stray status not drained quietly in idle (stsrdy=%b busy=%b)", s_axis_s2mm_sts_tready, busy); end
    run_xfer(32'h7000, 16'h0020, -1, 4'h8, 0, 100, 0, 0, "after_drain");
  endtask

  task automatic test_abort;
    int resp_seen;
    resp_seen = 0;
    @(posedge clk); #1;
    wreq_valid = 1; wreq_addr = 32'h8000; wreq_size = 16'h0040;
    m_axis_s2mm_cmd_tready = 1; wdata_valid = 1; wdata = 64'hDEAD;
    @(posedge clk); #1;
    wreq_valid = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    n_checks++;
    if ({busy, m_axis_s2mm_tvalid, wresp_valid, m_axis_s2mm_cmd_tvalid, wdata_ready} !== 5'b0) begin
      n_fail++; $display("FAIL abort: busy=%b tvalid=%b wresp=%b want all 0", busy, m_axis_s2mm_tvalid, wresp_valid);
    end
    idle_inputs();
    @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (wresp_valid) resp_seen++; end
    n_checks++;
    if (resp_seen != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort response: got %0d wresp pulses busy=%b want 0 0", resp_seen, busy);
    end
    exp_tag = 0;
    @(posedge clk); #1;
    run_xfer(32'h8100, 16'h0011, -1, 4'h8, 0, 90, 0, 0, "after_abort");
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 20; t++)
      run_xfer($urandom, 16'($urandom_range(1, 200)), -1, 4'h8, 0, $urandom_range(30, 100), 0, 1, "random");
  endtask

`ifdef S2MM_STS_TIMEOUT_EN
  task automatic test_timeout;
    run_xfer(32'h9000, 16'h0020, -1, 4'h8, 0, 100, 1, 0, "timeout");
    test_drain();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_status_err();
    test_len_err();
    test_zero_size();
    test_drain();
    test_abort();
    test_back_to_back();
`ifdef S2MM_STS_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/s2mm_wr_bridge.md
Name: s2mm_wr_bridge

Overview:
Write-side bridge between the test write interface (wreq/wdata/wresp) and an AXI DataMover S2MM channel. Each accepted write request becomes one 72-bit DataMover command. The block forwards the data beats as AXI-Stream with tkeep/tlast, collects the S2MM status word and returns a single-cycle wresp.

Parameters:
S2MM_DATA_WIDTH, 64, data beat width in bits (power of 2, >= 8)
S2MM_CMD_WIDTH, 72, DataMover command width (fixed 72 for 32-bit address)
S2MM_ADDR_WIDTH, 32, byte address width
S2MM_SIZE_WIDTH, 16, request size in bytes (<= 23)
S2MM_STS_WIDTH, 32, status width; only bits [7:0] are decoded
TIMEOUT_CYCLES, 4096, status watchdog limit; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
wreq_ready  out  1  high only in IDLE
wreq_valid  in  1  request strobe; sampled only when wreq_ready=1
wreq_addr  in  S2MM_ADDR_WIDTH  start byte address
wreq_size  in  S2MM_SIZE_WIDTH  length in bytes
wdata_ready  out  1  data accept
wdata_valid  in  1  data valid
wdata_last  in  1  source's last-beat flag; qualified by valid&ready
wdata  in  S2MM_DATA_WIDTH  beat
wresp_valid  out  1  one-cycle response strobe
wresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
m_axis_s2mm_cmd_tvalid/tready/tdata  out/in/out  1/1/S2MM_CMD_WIDTH  command stream
m_axis_s2mm_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/DW/DW/8/1  data stream
s_axis_s2mm_sts_tvalid/tready/tdata  in/out/in  1/1/S2MM_STS_WIDTH  status stream
busy  out  1  state != IDLE

Behaviour:
Interface decision:
- Single clock clk; rst is asynchronous, active-high.
- All outputs reset to 0. The 4-bit tag counter and the beat counter reset to 0.

FSM: IDLE -> CMD -> DATA -> STS -> RESP -> IDLE.
- IDLE: a request is accepted when wreq_valid=1. Latch addr and size, then go to CMD the next cycle.
  - size==0: skip CMD, DATA and STS; go straight to RESP with wresp=10.
- CMD: drive tdata with:
  - [22:0] = size zero-extended
  - [23] = 1 (INCR)
  - [29:24] = 0
  - [30] = 1 (EOF)
  - [31] = 0
  - [63:32] = addr
  - [67:64] = tag
  - [71:68] = 0
  - Hold tvalid until tready. On handshake, tag increments (wraps 15->0) and state goes to DATA.
- DATA: beats = ceil(size / (DW/8)).
  - The output uses a 1-deep register slice.
  - wdata_ready = DATA && !done && (!m_tvalid || m_tready).
  - Input-to-output latency is 1 cycle.
  - tlast is asserted when the beat count reaches beats-1.
  - tkeep is all ones, except on the last beat: rem = size mod (DW/8); keep = (rem==0) ? all ones : (1<<rem)-1.
  - len_err is set if wdata_last is high on a non-final accepted beat, or low on the final accepted beat. The beat count always governs; beats are never dropped or padded.
  - Leave DATA when the final beat completes its output handshake.
- STS: sts_tready=1. On sts_tvalid, decode:
  - DECERR if sts[5]
  - else SLVERR if sts[6] | sts[4] | (sts[3:0] != tag-1) | len_err | !sts[7]
  - else OKAY
- RESP: wresp_valid=1 for exactly one cycle, then IDLE. wresp returns to 0 with wresp_valid. len_err clears.
- sts_tready is also 1 in IDLE, so stray status words are drained and ignored.
- wreq_valid while not ready is dropped. No queueing.
- Reset mid-operation aborts immediately to IDLE with no response. An in-flight DataMover transfer is not cleaned up.

Optional Feature:
S2MM_STS_TIMEOUT_EN
- Defined: a counter runs in STS. When it reaches TIMEOUT_CYCLES-1 without status, go to RESP with wresp=10. A late status is drained in IDLE.
- Undefined: STS waits indefinitely, and no counter logic is present.

Decomposition:
- Package s2mm_bridge_pkg holds:
  - FSM state encoding
  - wresp codes (OKAY/SLVERR/DECERR)
  - command field offsets (BTT_LSB, TYPE_BIT, EOF_BIT, SADDR_LSB, TAG_LSB)
  - status bit indices
- Sub-module s2mm_axis_reg: 1-deep AXIS output register with tvalid/tready, carrying tdata/tkeep/tlast.

Test Plan:
- Reset: hold rst for 5 cycles -> all outputs 0, wreq_ready=1 after release.
- addr=0x1000, size=0x0100, sts=0x80 -> cmd tdata=72'h00_00001000_40800100; 32 beats 0..31 with keep=0xFF, tlast on beat 31; wresp=00 pulsed 1 cycle; next cmd tag=1.
- size=0x0014 -> BTT=20; 3 beats, last tkeep=0x0F, tlast on beat 2.
- m_axis_s2mm_tready random 50%, size=0x0100 -> 32 beats in order, none lost or duplicated, tdata equal to input.
- Status 0x41 -> wresp=10; wdata_last high at beat 10 of 32 -> still 32 beats, wresp=10.
- size=0 -> no cmd_tvalid, wresp=10 within 2 cycles; with S2MM_STS_TIMEOUT_EN and no status -> wresp=10 after TIMEOUT_CYCLES.
